cyclic_fold_writer: RTL and testbench
=====================================

# cyclic_fold_writer

Write-side counterpart to the wrap-around extractor: XOR-accumulates one shifted 32-bit partial-product word into the cyclic accumulator RAM, folding bits that cross the polynomial end (bit 17669) back to words 0/1. Sits between the sparse-multiply shift datapath and the single-port accumulator RAM (553 words; word 552 carries 5 valid bits [4:0]). Each placement is done as a sequence of 3-cycle read-modify-write (RMW) operations.

## Interface
- WORD_WIDTH, 32, data word width (only 32 supported)
- ADDR_WIDTH, 10, RAM address width
- LAST_WORD, 552, index of the partial top word
- TAIL_BITS, 5, valid bits in LAST_WORD

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- in_word  in  32  partial-product word w
- in_idx  in  10  destination word index
- in_shift  in  5  left bit shift within word
- busy  out  1  high from cycle after accepted start until done cycle inclusive
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse with done for illegal in_idx
- mem_addr  out  10  RAM address
- mem_rd_en  out  1  read strobe; mem_rdata valid the following cycle
- mem_rdata  in  32  RAM read data
- mem_wr_en  out  1  write strobe
- mem_wdata  out  32  write data

## Operation
- Accept: IDLE with start=1 latches inputs; s[63:0] = {32'b0,w} << in_shift; lo = s[31:0], hi = s[63:32].
- Op list (order fixed, addr:mask):
  - idx ≤ 550: (idx: lo), (idx+1: hi).
  - idx = 551: (551: lo), (552: {27'b0, hi[4:0]}), (0: hi >> 5).
  - idx = 552: (552: {27'b0, lo[4:0]}), (0: s[36:5]), (1: {5'b0, s[63:37]}).
  - idx ≥ 553: no ops; err=1, done=1 next cycle; no RAM access.
- States: IDLE -> RD (mem_rd_en=1, mem_addr=op addr) -> WAIT (capture mem_rdata) -> WR (mem_wr_en=1, same addr, mem_wdata = captured ^ mask) -> RD of next op, or DONE -> IDLE.
- Word 552 bits [31:5] preserved (mask zero there).
- start while busy=1 ignored (not queued).
- mem_rd_en and mem_wr_en never high in the same cycle.

## Timing
- All outputs registered; reset values: busy=0, done=0, err=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
- start at edge 0 -> first RD in cycle 1; each op 3 cycles; done in cycle 3·N+1 (N = ops performed): 2 ops -> cycle 7, 3 ops -> cycle 10; illegal idx -> done/err in cycle 1.
- Next start accepted in the cycle after done (back-to-back throughput 3·N+2 cycles).
- rst mid-operation: return to IDLE next edge, all outputs to reset values; pending WR not issued, an already-issued write stands.

## Configuration
- CYCLIC_FOLD_SKIP_ZERO_EN defined: ops whose mask is all-zero are dropped at accept time; zero cycles spent; if all ops zero, done in cycle 1 with no RAM access, err=0.
- Undefined: every op in the list executes, including zero-mask RMWs (rewrites identical data).

## Test plan
- idx=10, w=0x8000_0001, shift=4 -> word10 ^= 0x0000_0010, word11 ^= 0x0000_0008; done cycle 7.
- idx=551, w=0xFFFF_FFFF, shift=8 -> word551 ^= 0xFFFF_FF00, word552 ^= 0x1F, word0 ^= 0x7; word552[31:5] unchanged; done cycle 10.
- idx=552, w=0x0000_00FF, shift=0 -> word552 ^= 0x1F, word0 ^= 0x7; word1 rewritten unchanged, done cycle 10 without macro; word1 untouched, done cycle 7 with macro.
- idx=553 -> err+done in cycle 1, mem_rd_en/mem_wr_en stay 0; idx=10, w=0x1, shift=0 with macro -> only word10 RMW, done cycle 4.
- start pulsed again while busy -> ignored, single op sequence; rst asserted during WAIT of first op -> no mem_wr_en, all outputs 0 next cycle, RAM unchanged.

Source files
------------

// File: rtl/cyclic_fold_writer.sv
// rtl/cyclic_fold_writer.sv - XOR-folds one shifted word into the cyclic accumulator RAM via RMW ops; optional macro CYCLIC_FOLD_SKIP_ZERO_EN
module cyclic_fold_writer #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LAST_WORD  = 552,
    parameter int TAIL_BITS  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_word,
    input  logic [ADDR_WIDTH-1:0] in_idx,
    input  logic [4:0]            in_shift,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_rd_en,
    input  logic [WORD_WIDTH-1:0] mem_rdata,
    output logic                  mem_wr_en,
    output logic [WORD_WIDTH-1:0] mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LAST_WORD);
    localparam logic [ADDR_WIDTH-1:0] PRE_ADDR  = ADDR_WIDTH'(LAST_WORD - 1);
    localparam logic [WORD_WIDTH-1:0] TAIL_MASK =
        {{(WORD_WIDTH - TAIL_BITS){1'b0}}, {TAIL_BITS{1'b1}}};

    // candidate op list straight from the placement rules
    logic [2*WORD_WIDTH-1:0] shifted;
    logic [WORD_WIDTH-1:0]   lo;
    logic [WORD_WIDTH-1:0]   hi;
    logic [ADDR_WIDTH-1:0]   cand_addr [3];
    logic [WORD_WIDTH-1:0]   cand_mask [3];
    logic [1:0]              cand_cnt;
    logic                    idx_bad;

    // accepted op list (possibly compacted)
    logic [ADDR_WIDTH-1:0]   acc_addr [3];
    logic [WORD_WIDTH-1:0]   acc_mask [3];
    logic [1:0]              acc_cnt;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   op_addr_q [3];
    logic [ADDR_WIDTH-1:0]   op_addr_d [3];
    logic [WORD_WIDTH-1:0]   op_mask_q [3];
    logic [WORD_WIDTH-1:0]   op_mask_d [3];
    logic [1:0]              op_cnt_q, op_cnt_d;
    logic [1:0]              op_sel_q, op_sel_d;
    logic [1:0]              op_nxt;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic                    mem_rd_en_q, mem_rd_en_d;
    logic                    mem_wr_en_q, mem_wr_en_d;
    logic [WORD_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;

    // split the shifted word into RMW ops, folding bits past the polynomial end to words 0/1
    always_comb begin
        shifted  = {{WORD_WIDTH{1'b0}}, in_word} << in_shift;
        lo       = shifted[WORD_WIDTH-1:0];
        hi       = shifted[2*WORD_WIDTH-1:WORD_WIDTH];
        idx_bad  = 1'b0;
        cand_cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            cand_addr[i] = '0;
            cand_mask[i] = '0;
        end
        if (in_idx < PRE_ADDR) begin
            cand_addr[0] = in_idx;
            cand_mask[0] = lo;
            cand_addr[1] = in_idx + ADDR_WIDTH'(1);
            cand_mask[1] = hi;
            cand_cnt     = 2'd2;
        end else if (in_idx == PRE_ADDR) begin
            cand_addr[0] = PRE_ADDR;
            cand_mask[0] = lo;
            cand_addr[1] = LAST_ADDR;
            cand_mask[1] = hi & TAIL_MASK;
            cand_addr[2] = '0;
            cand_mask[2] = hi >> TAIL_BITS;
            cand_cnt     = 2'd3;
        end else if (in_idx == LAST_ADDR) begin
            cand_addr[0] = LAST_ADDR;
            cand_mask[0] = lo & TAIL_MASK;
            cand_addr[1] = '0;
            cand_mask[1] = WORD_WIDTH'(shifted >> TAIL_BITS);
            cand_addr[2] = ADDR_WIDTH'(1);
            cand_mask[2] = WORD_WIDTH'(shifted >> (WORD_WIDTH + TAIL_BITS));
            cand_cnt     = 2'd3;
        end else begin
            idx_bad = 1'b1;
        end
    end

    // optionally drop zero-mask ops so they cost no cycles
    always_comb begin
        acc_cnt = 2'd0;
        for (int i = 0; i < 3; i++) begin
            acc_addr[i] = '0;
            acc_mask[i] = '0;
        end
`ifdef CYCLIC_FOLD_SKIP_ZERO_EN
        for (int i = 0; i < 3; i++) begin
            if ((2'(i) < cand_cnt) && (cand_mask[i] != '0)) begin
                acc_addr[acc_cnt] = cand_addr[i];
                acc_mask[acc_cnt] = cand_mask[i];
                acc_cnt           = acc_cnt + 2'd1;
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            acc_addr[i] = cand_addr[i];
            acc_mask[i] = cand_mask[i];
        end
        acc_cnt = cand_cnt;
`endif
    end

    // RMW sequencer: RD -> WAIT -> WR per op, then a one-cycle DONE
    always_comb begin
        state_d     = state_q;
        op_addr_d   = op_addr_q;
        op_mask_d   = op_mask_q;
        op_cnt_d    = op_cnt_q;
        op_sel_d    = op_sel_q;
        op_nxt      = op_sel_q + 2'd1;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_rd_en_d = 1'b0;
        mem_wr_en_d = 1'b0;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_addr_d = acc_addr;
                    op_mask_d = acc_mask;
                    op_cnt_d  = acc_cnt;
                    op_sel_d  = 2'd0;
                    busy_d    = 1'b1;
                    if (idx_bad || (acc_cnt == 2'd0)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = idx_bad;
                    end else begin
                        state_d     = S_RD;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = acc_addr[0];
                    end
                end
            end
            S_RD: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                state_d     = S_WR;
                mem_wr_en_d = 1'b1;
                mem_wdata_d = mem_rdata ^ op_mask_q[op_sel_q];
            end
            S_WR: begin
                if (op_nxt < op_cnt_q) begin
                    op_sel_d    = op_nxt;
                    state_d     = S_RD;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = op_addr_q[op_nxt];
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // state and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < 3; i++) begin
                op_addr_q[i] <= '0;
                op_mask_q[i] <= '0;
            end
            op_cnt_q    <= 2'd0;
            op_sel_q    <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_en_q <= 1'b0;
            mem_wr_en_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            op_addr_q   <= op_addr_d;
            op_mask_q   <= op_mask_d;
            op_cnt_q    <= op_cnt_d;
            op_sel_q    <= op_sel_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_wr_en_q <= mem_wr_en_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_wr_en = mem_wr_en_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_cyclic_fold_writer.sv
// tb/tb_cyclic_fold_writer.sv - self-checking bench for cyclic_fold_writer
module tb_cyclic_fold_writer;

    localparam int NW   = 553;
    localparam int POLY = 17669;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] in_word;
    logic [9:0]  in_idx;
    logic [4:0]  in_shift;
    logic        busy, done, err;
    logic [9:0]  mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_rdata, mem_wdata;

    always #5 clk = ~clk;

    cyclic_fold_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_word   (in_word),
        .in_idx    (in_idx),
        .in_shift  (in_shift),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata)
    );

    int checks   = 0;
    int failures = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    logic [31:0] seed_ram [NW];
    logic [31:0] ram      [NW];
    logic [31:0] exp_ram  [NW];
    logic        ram_load;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t exp_q [$];

    typedef struct {
        int          idx;
        logic [31:0] w;
        int          sh;
        logic        exp_err;
        int          cyc_plain;
        int          cyc_skip;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // single-port RAM model with one-cycle read latency
    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < NW; i++) ram[i] <= seed_ram[i];
        end else if (int'(mem_addr) < NW) begin
            if (mem_wr_en) ram[mem_addr] <= mem_wdata;
            if (mem_rd_en) mem_rdata <= ram[mem_addr];
        end
    end

    // bus monitor and write scoreboard
    always @(negedge clk) begin
        if (mem_rd_en) rd_cnt++;
        if (mem_rd_en && mem_wr_en) begin
            failures++;
            $display("FAIL rd_wr_overlap actual=1 required=0");
        end
        if ((mem_rd_en || mem_wr_en) && int'(mem_addr) >= NW) begin
            failures++;
            $display("FAIL addr_range actual=%0d required=<%0d", mem_addr, NW);
        end
        if (mem_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", mem_addr, mem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr_data", {22'd0, mem_addr, mem_wdata}, {22'd0, e.a, e.d});
            end
        end
    end

    // bit-level reference: each set bit lands at (idx*32+shift+b) mod 17669
    function automatic logic [31:0] fold_mask(input int idx, input logic [31:0] w, input int sh, input int addr);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            if (w[b]) begin
                int p;
                p = (idx * 32 + sh + b) % POLY;
                if (p / 32 == addr) m[p % 32] = 1'b1;
            end
        end
        return m;
    endfunction

    task automatic plan(input int idx, input logic [31:0] w, input int sh, output int n);
        int addrs [$];
        n = 0;
        if (idx <= 550)      addrs = '{idx, idx + 1};
        else if (idx == 551) addrs = '{551, 552, 0};
        else if (idx == 552) addrs = '{552, 0, 1};
        foreach (addrs[k]) begin
            logic [31:0] m;
            wr_t e;
            m = fold_mask(idx, w, sh, addrs[k]);
`ifdef CYCLIC_FOLD_SKIP_ZERO_EN
            if (m == '0) continue;
`endif
            e.a = 10'(addrs[k]);
            e.d = exp_ram[addrs[k]] ^ m;
            exp_ram[addrs[k]] = e.d;
            exp_q.push_back(e);
            n++;
        end
    endtask

    task automatic ram_compare(input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < NW; i++) if (ram[i] !== exp_ram[i]) bad++;
        chk(nm, 64'(bad), 64'd0);
    endtask

    // drive start at the coming edge 0, then watch cycles 1.. for done
    task automatic wait_done(input string nm, input logic exp_err, input int exp_cyc, input int rd0, input int n);
        int cyc;
        bit got;
        cyc = 1;
        got = 0;
        while (cyc <= 40) begin
            if (cyc == 1) chk({nm, "_busy_c1"}, 64'(busy), 64'd1);
            if (done) begin
                got = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done_seen"}, 64'(got), 64'd1);
        chk({nm, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({nm, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        chk({nm, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        chk({nm, "_writes_left"}, 64'(exp_q.size()), 64'd0);
        chk({nm, "_reads"}, 64'(rd_cnt - rd0), 64'(n));
        ram_compare({nm, "_ram"});
    endtask

    task automatic run_txn(input string nm, input int idx, input logic [31:0] w, input int sh,
                           input logic exp_err, input int exp_cyc);
        int n, rd0;
        plan(idx, w, sh, n);
        rd0 = rd_cnt;
        in_idx   = 10'(idx);
        in_word  = w;
        in_shift = 5'(sh);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nm, exp_err, exp_cyc, rd0, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, rd0, wr0, exp_cyc;
        vecs[0]  = '{10,  32'h8000_0001, 4,  1'b0, 7,  7};
        vecs[1]  = '{551, 32'hFFFF_FFFF, 8,  1'b0, 10, 10};
        vecs[2]  = '{552, 32'h0000_00FF, 0,  1'b0, 10, 7};
        vecs[3]  = '{553, 32'h1234_5678, 3,  1'b1, 1,  1};
        vecs[4]  = '{10,  32'h0000_0001, 0,  1'b0, 7,  4};
        vecs[5]  = '{0,   32'hDEAD_BEEF, 31, 1'b0, 7,  7};
        vecs[6]  = '{550, 32'h1234_5678, 16, 1'b0, 7,  7};
        vecs[7]  = '{1023, 32'hFFFF_FFFF, 0, 1'b1, 1,  1};
        vecs[8]  = '{551, 32'h0000_0001, 0,  1'b0, 10, 4};
        vecs[9]  = '{552, 32'hFFFF_FFFF, 31, 1'b0, 10, 7};
        vecs[10] = '{552, 32'h0000_0000, 0,  1'b0, 10, 1};

        for (int i = 0; i < NW; i++) begin
            seed_ram[i] = $urandom;
            exp_ram[i]  = seed_ram[i];
        end
        rst      = 1'b1;
        ram_load = 1'b1;
        start    = 1'b0;
        in_word  = '0;
        in_idx   = '0;
        in_shift = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        ram_load = 1'b0;
        chk("reset_outputs", {20'd0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 64'd0);

        foreach (vecs[i]) begin
`ifdef CYCLIC_FOLD_SKIP_ZERO_EN
            exp_cyc = vecs[i].cyc_skip;
`else
            exp_cyc = vecs[i].cyc_plain;
`endif
            run_txn($sformatf("vec%0d", i), vecs[i].idx, vecs[i].w, vecs[i].sh, vecs[i].exp_err, exp_cyc);
        end

        // start while busy must be ignored
        plan(30, 32'hA5A5_A5A5, 3, n);
        rd0 = rd_cnt;
        in_idx = 10'd30; in_word = 32'hA5A5_A5A5; in_shift = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        in_idx = 10'd100; in_word = 32'hFFFF_0000; in_shift = 5'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        in_idx = 10'd0; in_word = '0; in_shift = '0;
        wait_done("busy_start", 1'b0, 7 - 2, rd0, n);
        repeat (5) @(negedge clk);
        chk("busy_start_no_extra_reads", 64'(rd_cnt - rd0), 64'(n));

        // reset during WAIT of the first op: no write, outputs cleared
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        in_idx = 10'd10; in_word = 32'h0000_00FF; in_shift = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_test_rd_c1", 64'(mem_rd_en), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {20'd0, busy, done, err, mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, 64'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_no_write", 64'(wr_cnt - wr0), 64'd0);
        chk("rst_mid_one_read", 64'(rd_cnt - rd0), 64'd1);
        ram_compare("rst_mid_ram");

        // accepted again after reset
        run_txn("post_rst", 200, 32'h0F0F_0F0F, 12, 1'b0, 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
